// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of one fifo write port.
// Ports: clk, rst_n (async low); req/req_data from N_REQ requesters;
//   gnt one-hot accept; fifo_full backpressure; push/wdata to the fifo;
//   owner = current/last owner index; busy = 1 while a burst is open.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 16,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4,
    localparam int OW = (N_REQ > 2) ? $clog2(N_REQ) : 1,
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       gnt,
    input  logic                   fifo_full,
    output logic                   push,
    output logic [WIDTH-1:0]       wdata,
    output logic [OW-1:0]          owner,
    output logic                   busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state, state_n;
    logic [OW-1:0] rr_ptr, rr_n, owner_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [OW-1:0] start, pick;
    logic          found, hold;

    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] x);
        if (int'(x) >= N_REQ - 1) return '0;
        return x + 1'b1;
    endfunction

    // Scan start: on early release the scan begins after the old owner,
    // so the next requester can be granted in the same cycle.
    always_comb begin
        start = (state == BURST) ? wrap_inc(owner) : rr_ptr;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int s;
            s = int'(start) + k;
            if (s >= N_REQ) s = s - N_REQ;
            if (!found && req[s]) begin
                found = 1'b1;
                pick  = OW'(s);
            end
        end
    end

    assign hold    = (state == BURST) && req[owner];
    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        gnt     = '0;
        state_n = state;
        owner_n = owner;
        rr_n    = rr_ptr;
        cnt_n   = cnt;
        if (hold) begin
            // A stalled burst keeps owner and count.
            if (!fifo_full) begin
                gnt[owner] = 1'b1;
                if (cnt_inc == CW'(MAX_BURST)) begin
                    state_n = IDLE;
                    rr_n    = wrap_inc(owner);
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
        end else begin
            if (state == BURST) begin
                state_n = IDLE;
                rr_n    = wrap_inc(owner);
                cnt_n   = '0;
            end
            if (!fifo_full && found) begin
                gnt[pick] = 1'b1;
                owner_n   = pick;
                if (MAX_BURST == 1) begin
                    state_n = IDLE;
                    rr_n    = wrap_inc(pick);
                end else begin
                    state_n = BURST;
                    cnt_n   = CW'(1);
                end
            end
        end
        // Outputs are quiet while reset is held.
        if (!rst_n) gnt = '0;
    end

    always_comb begin
        wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) wdata = req_data[i*WIDTH +: WIDTH];
        end
    end

    assign push = |gnt;
    assign busy = (state == BURST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            rr_ptr <= rr_n;
            cnt    <= cnt_n;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for fifo_wr_arbiter.
// Two instances: 4 req / burst 4, and 3 req / burst 1.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  gnt;
    logic        fifo_full = 1'b0;
    logic        push;
    logic [15:0] wdata;
    logic [1:0]  owner;
    logic        busy;

    logic [2:0]  req2 = '0;
    logic [47:0] req_data2 = '0;
    logic [2:0]  gnt2;
    logic        full2 = 1'b0;
    logic        push2;
    logic [15:0] wdata2;
    logic [1:0]  owner2;
    logic        busy2;

    fifo_wr_arbiter #(.WIDTH(16), .N_REQ(4), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .gnt(gnt), .fifo_full(fifo_full), .push(push), .wdata(wdata),
        .owner(owner), .busy(busy)
    );

    fifo_wr_arbiter #(.WIDTH(16), .N_REQ(3), .MAX_BURST(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .req_data(req_data2),
        .gnt(gnt2), .fifo_full(full2), .push(push2), .wdata(wdata2),
        .owner(owner2), .busy(busy2)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit act;
        int own;
        int beats;
        int start;
    } mst_t;

    typedef struct {
        logic [3:0]  g;
        logic [15:0] wd;
        logic [1:0]  own;
        logic        bz;
        logic [2:0]  g2;
        logic [15:0] wd2;
        logic [1:0]  own2;
        logic        bz2;
    } exp_t;

    exp_t q[$];
    mst_t m1 = '{default: 0};
    mst_t m2 = '{default: 0};
    int   checks = 0;
    int   errors = 0;

    // Reference: ownership is a count of beats taken; when it is not
    // continuing, the winner is the nearest requester at or after 'start'.
    function automatic mst_t step(input mst_t s, input logic [7:0] r,
                                  input bit full, input int n,
                                  input int mb, output int g);
        mst_t t = s;
        g = -1;
        if (t.act && r[t.own]) begin
            if (!full) begin
                g = t.own;
                t.beats = t.beats + 1;
                if (t.beats == mb) begin
                    t.act   = 0;
                    t.start = (t.own + 1) % n;
                end
            end
        end else begin
            int best = n;
            if (t.act) begin
                t.act   = 0;
                t.start = (t.own + 1) % n;
            end
            for (int i = 0; i < n; i++) begin
                int d = (i - t.start + n) % n;
                if (r[i] && d < best) begin
                    best = d;
                    g    = i;
                end
            end
            if (full) g = -1;
            if (g >= 0) begin
                t.own   = g;
                t.beats = 1;
                if (mb == 1) t.start = (g + 1) % n;
                else t.act = 1;
            end
        end
        return t;
    endfunction

    task automatic cyc(input logic [3:0] r, input logic [2:0] r2,
                       input bit full, input bit rst);
        exp_t e = '{default: '0};
        int   g1, g2;
        @(posedge clk);
        #1;
        rst_n     = rst;
        req       = r;
        req2      = r2;
        fifo_full = full;
        req_data  = {$urandom(), $urandom()};
        req_data2 = {$urandom(), 16'($urandom())};
        if (!rst) begin
            m1 = '{default: 0};
            m2 = '{default: 0};
        end else begin
            e.own  = 2'(m1.own);
            e.bz   = m1.act;
            e.own2 = 2'(m2.own);
            e.bz2  = m2.act;
            m1 = step(m1, {4'b0, r}, full, 4, 4, g1);
            m2 = step(m2, {5'b0, r2}, 1'b0, 3, 1, g2);
            if (g1 >= 0) begin
                e.g  = 4'(1 << g1);
                e.wd = req_data[g1*16 +: 16];
            end
            if (g2 >= 0) begin
                e.g2  = 3'(1 << g2);
                e.wd2 = req_data2[g2*16 +: 16];
            end
        end
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("gnt",    16'(gnt),    16'(e.g));
            chk("push",   16'(push),   16'(|e.g));
            chk("wdata",  wdata,       e.wd);
            chk("owner",  16'(owner),  16'(e.own));
            chk("busy",   16'(busy),   16'(e.bz));
            chk("gnt2",   16'(gnt2),   16'(e.g2));
            chk("push2",  16'(push2),  16'(|e.g2));
            chk("wdata2", wdata2,      e.wd2);
            chk("owner2", 16'(owner2), 16'(e.own2));
            chk("busy2",  16'(busy2),  16'(e.bz2));
        end
    end

    initial begin
        // reset held with all requesters active
        repeat (3) cyc(4'hF, 3'b111, 1'b0, 1'b0);
        // single requester: back-to-back re-grant
        repeat (10) cyc(4'b0001, 3'b111, 1'b0, 1'b1);
        repeat (2) cyc(4'b0000, 3'b111, 1'b0, 1'b1);
        // all requesting: rotation in bursts of 4
        repeat (20) cyc(4'hF, 3'b111, 1'b0, 1'b1);
        // backpressure inside a burst
        for (int k = 0; k < 12; k++)
            cyc(4'hF, 3'b111, (k >= 2 && k < 5), 1'b1);
        // early release handing over in the same cycle
        repeat (3) cyc(4'b0000, 3'b111, 1'b0, 1'b1);
        repeat (2) cyc(4'b0001, 3'b111, 1'b0, 1'b1);
        repeat (3) cyc(4'b0100, 3'b111, 1'b0, 1'b1);
        // reset in the middle of a burst
        cyc(4'b0100, 3'b111, 1'b0, 1'b0);
        repeat (6) cyc(4'hF, 3'b111, 1'b0, 1'b1);
        // random traffic with backpressure and occasional reset
        for (int k = 0; k < 500; k++) begin
            logic [3:0] r;
            logic [2:0] r2;
            r  = 4'($urandom());
            r2 = 3'($urandom());
            cyc(r, r2, ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 99) != 0));
        end
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
